// File: rtl/data_memory_lat.sv
// data_memory_lat: word-organised backing memory with a fixed access latency.
// One request (word with byte enables, or aligned full line) is accepted over
// valid/ready, held for LATENCY cycles, then committed and answered with a
// single-cycle response pulse. Storage itself is never reset.
module data_memory_lat #(
    parameter int WORD_W      = 32,
    parameter int LINE_WORDS  = 4,
    parameter int DEPTH_WORDS = 4096,
    parameter int ADDR_W      = 32,
    parameter int LATENCY     = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic                         req_line,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [WORD_W/8-1:0]          req_be,
    input  logic [WORD_W*LINE_WORDS-1:0] req_wdata,
    output logic                         resp_valid,
    output logic [WORD_W*LINE_WORDS-1:0] resp_rdata
);

    localparam int BYTES  = WORD_W / 8;
    localparam int OFF_W  = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int LINE_W = WORD_W * LINE_WORDS;
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [IDX_W-1:0] LINE_MASK = IDX_W'(LINE_WORDS - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;

    // Captured request; data-only, so not reset.
    logic               we_q;
    logic               line_q;
    logic [IDX_W-1:0]   idx_q;
    logic [BYTES-1:0]   be_q;
    logic [LINE_W-1:0]  wdata_q;

    logic [WORD_W-1:0]  mem [DEPTH_WORDS];

    logic               accept;
    logic               commit;
    logic [IDX_W-1:0]   req_idx;
    logic [LINE_W-1:0]  line_rd;
    logic               addr_unused;

    assign accept = req_valid && req_ready;
    assign commit = (state == WAIT) && (cnt == '0);

    // Offset and high address bits are deliberately dropped by the decode.
    assign addr_unused = ^req_addr;

    // Word index from byte address, wrapped to the depth; lines are aligned down.
    always_comb begin
        req_idx = req_addr[OFF_W +: IDX_W];
        if (req_line) begin
            req_idx = req_idx & ~LINE_MASK;
        end
    end

    // Gather a whole line from the aligned base index of the held request.
    always_comb begin
        line_rd = '0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            line_rd[i*WORD_W +: WORD_W] = mem[idx_q | IDX_W'(i)];
        end
    end

    // Latch the request on the accept edge; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            line_q  <= req_line;
            idx_q   <= req_idx;
            be_q    <= req_be;
            wdata_q <= req_wdata;
        end
    end

    // Commit writes on the commit edge; commit is false while reset holds the FSM idle.
    always_ff @(posedge clk) begin
        if (commit && we_q) begin
            if (line_q) begin
                for (int i = 0; i < LINE_WORDS; i++) begin
                    mem[idx_q | IDX_W'(i)] <= wdata_q[i*WORD_W +: WORD_W];
                end
            end else begin
                for (int b = 0; b < BYTES; b++) begin
                    if (be_q[b]) begin
                        mem[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Control FSM: accept, count down the latency, then respond and reopen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= WAIT;
                        cnt       <= CNT_W'(LATENCY - 1);
                        req_ready <= 1'b0;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state      <= IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b1;
                        if (we_q) begin
                            resp_rdata <= '0;
                        end else if (line_q) begin
                            resp_rdata <= line_rd;
                        end else begin
                            resp_rdata <= LINE_W'(mem[idx_q]);
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_lat.sv
// tb_data_memory_lat: directed self-checking bench for data_memory_lat.
module tb_data_memory_lat;

    localparam int WORD_W      = 32;
    localparam int LINE_WORDS  = 4;
    localparam int DEPTH_WORDS = 4096;
    localparam int ADDR_W      = 32;
    localparam int LATENCY     = 5;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic         req_line;
    logic [31:0]  req_addr;
    logic [3:0]   req_be;
    logic [127:0] req_wdata;
    logic         resp_valid;
    logic [127:0] resp_rdata;

    int checks;
    int failures;
    int cyc;
    int acc_q[$];

    data_memory_lat #(
        .WORD_W(WORD_W), .LINE_WORDS(LINE_WORDS), .DEPTH_WORDS(DEPTH_WORDS),
        .ADDR_W(ADDR_W), .LATENCY(LATENCY)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_line(req_line), .req_addr(req_addr),
        .req_be(req_be), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Negedge counter used as a time base for accept-edge spacing.
    always @(negedge clk) cyc <= cyc + 1;

    // Record the cycle of every accept edge.
    always @(posedge clk) begin
        if (rst && req_valid && req_ready) acc_q.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request with busy-window garbage on the inputs; checks handshake timing.
    task automatic do_req(input logic we, input logic line, input logic [31:0] addr,
                          input logic [3:0] be, input logic [127:0] wd,
                          input string tag, output logic [127:0] rd);
        int  n;
        bit  got;
        rd = '0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_line = line;
        req_addr = addr; req_be = be; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk({tag, "_ready_timeout"}, {127'd0, req_ready}, 128'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        n = 1;
        req_we = 1'b1; req_line = 1'b1; req_be = 4'hF; req_wdata = '1;
        chk({tag, "_busy"}, {127'd0, req_ready}, 128'd0);
        got = 1'b0;
        while (n < 20) begin
            if (n == 4) req_valid = 1'b0;
            if (resp_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0; req_we = 1'b0; req_line = 1'b0; req_be = '0; req_wdata = '0;
        chk({tag, "_lat"}, 128'(n), 128'(LATENCY + 1));
        if (got) begin
            rd = resp_rdata;
            chk({tag, "_ready_at_resp"}, {127'd0, req_ready}, 128'd1);
            @(negedge clk);
            chk({tag, "_pulse"}, {127'd0, resp_valid}, 128'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] rd;
        int busy;
        int nresp;
        int n;
        int seen;

        checks = 0; failures = 0; cyc = 0;
        rst = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_line = 1'b0;
        req_addr = 32'h10; req_be = 4'hF; req_wdata = 128'h1234;

        // Reset held with a pending request: nothing accepted, outputs cleared.
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("rst_ready", {127'd0, req_ready}, 128'd0);
        chk("rst_resp_valid", 128'(seen), 128'd0);
        chk("rst_rdata", resp_rdata, 128'd0);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", {127'd0, req_ready}, 128'd1);

        // Byte-enabled word writes then word read.
        do_req(1'b1, 1'b0, 32'h10, 4'hF, 128'hDEADBEEF, "wr_full", rd);
        chk("wr_full_rdata", rd, 128'd0);
        do_req(1'b1, 1'b0, 32'h10, 4'b0101, 128'h11223344, "wr_be", rd);
        chk("wr_be_rdata", rd, 128'd0);
        do_req(1'b0, 1'b0, 32'h12, 4'h0, 128'd0, "rd_be", rd);
        chk("rd_be_data", rd, 128'h0000_0000_0000_0000_0000_0000_DE22_BE44);

        // be=0 write is a no-op that still responds.
        do_req(1'b1, 1'b0, 32'h10, 4'h0, 128'hFFFFFFFF, "wr_be0", rd);
        chk("wr_be0_rdata", rd, 128'd0);
        do_req(1'b0, 1'b0, 32'h10, 4'h0, 128'd0, "rd_be0", rd);
        chk("rd_be0_data", rd, 128'h0000_0000_0000_0000_0000_0000_DE22_BE44);

        // Line write to unaligned address lands at base word 8.
        do_req(1'b1, 1'b1, 32'h23, 4'h0,
               128'h000000A3_000000A2_000000A1_000000A0, "wr_line", rd);
        chk("wr_line_rdata", rd, 128'd0);
        do_req(1'b0, 1'b0, 32'h2C, 4'h0, 128'd0, "rd_word_a3", rd);
        chk("rd_word_a3_data", rd, 128'h0000_0000_0000_0000_0000_0000_0000_00A3);
        do_req(1'b0, 1'b1, 32'h20, 4'h0, 128'd0, "rd_line", rd);
        chk("rd_line_data", rd, 128'h000000A3_000000A2_000000A1_000000A0);
        do_req(1'b0, 1'b1, 32'h2F, 4'h0, 128'd0, "rd_line_unal", rd);
        chk("rd_line_unal_data", rd, 128'h000000A3_000000A2_000000A1_000000A0);

        // Back-to-back reads with req_valid held high.
        @(negedge clk);
        acc_q.delete();
        req_valid = 1'b1; req_we = 1'b0; req_line = 1'b0; req_addr = 32'h10;
        busy = 0; nresp = 0; n = 0;
        while (nresp < 3 && n < 60) begin
            @(negedge clk);
            n++;
            if (acc_q.size() >= 3) req_valid = 1'b0;
            if (!req_ready) busy++;
            if (resp_valid) begin
                nresp++;
                chk("b2b_ready_at_resp", {127'd0, req_ready}, 128'd1);
                chk("b2b_rdata", resp_rdata, 128'h0000_0000_0000_0000_0000_0000_DE22_BE44);
            end
        end
        req_valid = 1'b0;
        chk("b2b_resp_count", 128'(nresp), 128'd3);
        chk("b2b_accept_count", 128'(acc_q.size()), 128'd3);
        if (acc_q.size() >= 3) begin
            chk("b2b_gap1", 128'(acc_q[1] - acc_q[0]), 128'(LATENCY + 1));
            chk("b2b_gap2", 128'(acc_q[2] - acc_q[1]), 128'(LATENCY + 1));
        end
        chk("b2b_busy_cycles", 128'(busy), 128'(3 * LATENCY));

        // Address wrap-around.
        do_req(1'b1, 1'b0, 32'(4 * DEPTH_WORDS), 4'hF, 128'h5A5A5A5A, "wr_wrap", rd);
        do_req(1'b0, 1'b0, 32'h0, 4'h0, 128'd0, "rd_wrap", rd);
        chk("rd_wrap_data", rd, 128'h0000_0000_0000_0000_0000_0000_5A5A_5A5A);

        // Reset in the middle of a write discards it.
        do_req(1'b1, 1'b0, 32'h40, 4'hF, 128'h1, "wr_40", rd);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_line = 1'b0;
        req_addr = 32'h40; req_be = 4'hF; req_wdata = 128'h2;
        chk("mid_ready_before", {127'd0, req_ready}, 128'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_ready", {127'd0, req_ready}, 128'd0);
        chk("mid_rst_rdata", resp_rdata, 128'd0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        rst = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("mid_no_resp", 128'(seen), 128'd0);
        do_req(1'b0, 1'b0, 32'h40, 4'h0, 128'd0, "rd_40", rd);
        chk("rd_40_data", rd, 128'h0000_0000_0000_0000_0000_0000_0000_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_memory_lat.md
# data_memory_lat

Parametrised, latency-modelling data memory that serves as the backing store behind the data cache, and as a direct uncached memory. It accepts one request at a time over a valid/ready handshake: either a single-word access with byte enables, or a full cache-line access. It then holds the request for a configurable number of cycles and returns a single-cycle response pulse carrying read data or a write acknowledge. Storage is a word-organised array; only the control and output registers are reset.

## Interface
- WORD_W, 32, data word width in bits; multiple of 8.
- LINE_WORDS, 4, words per cache line; power of two.
- DEPTH_WORDS, 4096, storage depth in words; power of two and a multiple of LINE_WORDS.
- ADDR_W, 32, request byte-address width.
- LATENCY, 5, cycles from request accept to commit/response; must be ≥ 1.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  registered; block can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_line  in  1  1 = full-line access, 0 = single-word access.
- req_addr  in  ADDR_W  byte address.
- req_be  in  WORD_W/8  byte enables; used only for word writes.
- req_wdata  in  WORD_W*LINE_WORDS  write data; word mode uses bits [WORD_W-1:0].
- resp_valid  out  1  registered single-cycle response pulse.
- resp_rdata  out  WORD_W*LINE_WORDS  registered read data; word i of the line is at [i*WORD_W +: WORD_W].

## Operation
- **FSM states:** IDLE, WAIT.
  - IDLE: req_ready=1.
  - IDLE→WAIT: on the accept edge (req_valid && req_ready). At this edge the block captures req_we, req_line, req_addr, req_be and req_wdata, clears req_ready, and loads the counter with LATENCY-1.
  - WAIT: the counter decrements each edge. On the edge where the counter is 0 (the commit edge), the access is performed, resp_valid is set, req_ready is set, and the FSM returns to IDLE.
  - After the accept edge, changes on any request input have no effect on the in-flight request.
- **Address decode:** word index = req_addr >> log2(WORD_W/8), taken modulo DEPTH_WORDS, so addresses wrap and never fault. Byte-offset bits are ignored.
- **Line mode:** the low log2(LINE_WORDS) bits of the word index are forced to 0, so the line is aligned. Word i of the line maps to base+i.
- **Word read:** resp_rdata[WORD_W-1:0] = mem[idx]; all upper bits are 0.
- **Line read:** all LINE_WORDS words are returned.
- **Word write:** only the bytes whose req_be bit is 1 are updated. req_be = 0 is a legal no-op write that still produces a response.
- **Line write:** all words are written from req_wdata; req_be is ignored.
- **Write response:** resp_valid pulses and resp_rdata = 0.
- **Ordering:** requests are strictly sequential. A read always observes every write whose commit edge precedes it.
- **resp_valid:** high for exactly one cycle; there is no response back-pressure.
- **Unspecified contents:** memory contents after power-up are unspecified; the bench must write before reading.
- **Reset (rst=0), asynchronous:**
  - Outputs and control: req_ready=0, resp_valid=0, resp_rdata=0, FSM=IDLE, counter=0.
  - Memory contents are not modified by reset.
  - An in-flight request is discarded. Its write is not committed if reset is asserted before its commit edge, and no response is issued.
- **After reset release:** req_ready rises on the first rising edge.

## Timing
- **Accept edge E0:** the first edge with req_valid=1 and req_ready=1.
- **Commit edge E0+LATENCY:**
  - Memory is written at this edge (writes), or sampled at this edge (reads).
  - resp_valid=1 and resp_rdata become valid in the cycle after this edge.
  - req_ready returns to 1 at this same edge.
- **Next request:** the next accept may occur at E0+LATENCY+1, coinciding with the resp_valid cycle. resp_valid falls at that edge regardless of whether a new request is accepted.
- **Throughput:** one request per LATENCY+1 cycles.
- **LATENCY=1:** commit on the edge immediately after accept.
- **Busy window:** req_valid high while req_ready=0 is ignored and has no side effects.

## Test plan
Defaults for all scenarios: WORD_W=32, LINE_WORDS=4, LATENCY=5.
- **Reset:** hold rst=0 with req_valid=1 → req_ready=0, resp_valid=0, resp_rdata=0, no accept. Release rst → req_ready=1 after one edge.
- **Byte-enabled word write/read:**
  - Word write 0x10 ← 0xDEADBEEF (be=0xF), then write 0x10 ← 0x11223344 with be=0b0101.
  - Word read 0x10 → resp_rdata = 0x...0000DE22BE44 (upper 96 bits 0).
  - resp_valid pulses 1 cycle, appearing after edge E0+5.
- **Line alignment:**
  - Line write to addr 0x23 (base word 8) with words {0xA0,0xA1,0xA2,0xA3}.
  - Word read 0x2C → 0xA3.
  - Line read 0x20 → all four words, 0xA0 in bits [31:0].
- **Back-to-back:**
  - Hold req_valid=1 for three consecutive reads → accepts occur exactly 6 edges apart.
  - req_ready=0 during each WAIT, and is high again in each resp_valid cycle.
- **Wrap-around:** word write at byte addr 4*DEPTH_WORDS ← 0x5A5A5A5A → word read at addr 0 returns 0x5A5A5A5A.
- **Reset mid-operation:**
  - After 0x40 holds 0x1, write 0x40 ← 0x2 and assert rst 2 cycles after accept → no resp_valid.
  - After release, read 0x40 → 0x1.
